// File: rtl/mult_div.sv
// rtl/mult_div.sv - iterative multiply/divide unit owning the HI/LO registers
// MULT/MULTU use shift-add and DIV/DIVU use restoring division, both on magnitudes; the sign is fixed up in FIXUP.
module mult_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             Start,
  input  logic [1:0]       MDOp,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic             HIWrite,
  input  logic             LOWrite,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP} state_t;

  state_t               state;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic [WIDTH-1:0]     a_orig;
  logic                 is_div;
  logic                 b_zero;
  logic                 neg_q;
  logic                 neg_r;

  logic                 signed_op;
  logic                 sign_a;
  logic                 sign_b;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       div_diff;
  logic [2*WIDTH-1:0]   mul_next;
  logic [2*WIDTH-1:0]   div_next;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [2*WIDTH-1:0]   prod;

  assign Busy = (state != IDLE);

  always_comb begin
    signed_op = ~MDOp[0];
    sign_a    = signed_op & SrcA[WIDTH-1];
    sign_b    = signed_op & SrcB[WIDTH-1];
    mag_a     = sign_a ? (~SrcA + 1'b1) : SrcA;
    mag_b     = sign_b ? (~SrcB + 1'b1) : SrcB;

    // Multiply: conditionally add the multiplicand into the upper half, then shift right.
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op_a} : '0);
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: shifted partial remainder minus divisor; a borrow in the top bit means restore.
    div_diff = acc[2*WIDTH-1:WIDTH-1] - {1'b0, op_b};
    div_next = div_diff[WIDTH] ? {acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], 1'b0}
                               : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    quo  = neg_q ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
    rem  = neg_r ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
    prod = neg_q ? (~acc + 1'b1) : acc;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= IDLE;
      count  <= '0;
      acc    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      a_orig <= '0;
      is_div <= 1'b0;
      b_zero <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Start) begin
            is_div <= MDOp[1];
            b_zero <= (SrcB == '0);
            a_orig <= SrcA;
            op_a   <= mag_a;
            op_b   <= mag_b;
            neg_q  <= sign_a ^ sign_b;
            neg_r  <= sign_a;
            // Multiply seeds the multiplier, divide seeds the dividend, both in the low half.
            acc    <= MDOp[1] ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
            count  <= '0;
            state  <= CALC;
          end else begin
            if (HIWrite) HI <= SrcA;
            if (LOWrite) LO <= SrcA;
          end
        end
        CALC: begin
          acc   <= is_div ? div_next : mul_next;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) state <= FIXUP;
        end
        FIXUP: begin
          if (is_div) begin
            if (b_zero) begin
              HI <= a_orig;
              LO <= '1;
            end else begin
              HI <= rem;
              LO <= quo;
            end
          end else begin
            {HI, LO} <= prod;
          end
          Done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mult_div.md
Name: mult_div

Overview:
- Iterative multiply/divide unit in the execute stage, alongside the ALU.
- Fed by the same SrcA/SrcB operand muxes as the ALU.
- Owns the architectural HI/LO registers, which are read by MFHI/MFLO through the writeback result mux.
- Implements MULT, MULTU, DIV, DIVU, MTHI and MTLO; exposes Busy so the control unit can stall on HI/LO hazards.

Parameters:
- WIDTH, 32, operand width; HI/LO are WIDTH bits each, the internal accumulator is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge
- reset_n  input  1  synchronous, active-low reset
- Start  input  1  launch an operation (sampled only in IDLE)
- MDOp  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SrcA  input  WIDTH  multiplicand / dividend; MTHI/MTLO data
- SrcB  input  WIDTH  multiplier / divisor
- HIWrite  input  1  MTHI: HI <= SrcA
- LOWrite  input  1  MTLO: LO <= SrcA
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse, HI/LO just updated by an operation
- HI  output  WIDTH  HI register
- LO  output  WIDTH  LO register

Behaviour:
- Interface: one clock; reset is synchronous and active-low. All state updates on the rising edge of clk.
- Reset: when reset_n=0 at an edge, state<=IDLE and HI, LO, Busy, Done, counter and accumulator <= 0.
  - Reset aborts any in-flight operation; HI/LO are not updated by the aborted operation.
- States: IDLE, CALC, FIXUP. Busy = (state != IDLE), decoded combinationally from the state register.
- IDLE:
  - Start=1 at edge k: latch SrcA, SrcB and MDOp; compute operand magnitudes (signed ops only); record the result signs; counter<=0; state<=CALC.
  - When Start=1, HIWrite and LOWrite in the same cycle are ignored (Start has priority).
  - Otherwise HIWrite and LOWrite each write SrcA into HI / LO at the edge; both may fire together.
- CALC:
  - Each of edges k+1..k+32 performs one iteration, counter+1.
  - Multiply: shift-add on a 2*WIDTH accumulator.
  - Divide: restoring, one quotient bit per iteration, operating on magnitudes.
  - After the 32nd iteration (edge k+32), state<=FIXUP.
- FIXUP (edge k+33): apply sign correction, write HI/LO, state<=IDLE. Done=1 during the cycle after edge k+33 only.
  - Total: Busy high 33 cycles; HI/LO valid from cycle k+34.
- Busy-time inputs: Start, HIWrite and LOWrite while Busy=1 are ignored.
  - The control unit stalls MFHI/MFLO, MTHI/MTLO and any new mult/div while Busy=1.
- Multiply result:
  - MULTU: {HI,LO} = unsigned 64-bit product.
  - MULT: {HI,LO} = signed 64-bit product; the magnitude product is negated (two's complement, 64-bit) when signA^signB.
- Divide result:
  - LO = quotient truncated toward zero; HI = remainder, with the sign of the dividend (DIV).
  - DIVU operates on the unsigned values.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. The magnitude path handles this naturally with no exception.
- Divide by zero (SrcB=0, DIV or DIVU): LO=0xFFFFFFFF, HI=original SrcA. Still takes the full 33 cycles.
- HI/LO hold their values in all other cycles.

Test Plan:
- Reset/MULTU: reset_n=0 then 1; check HI=LO=0, Busy=0. MULTU 0xFFFFFFFF*0xFFFFFFFF with Start at edge k -> Busy=1 for exactly 33 cycles; Done pulse one cycle; HI=0xFFFFFFFE, LO=0x00000001.
- MULT signed: 0xFFFFFFFD*0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. Then 0x80000000*0x80000000 -> HI=0x40000000, LO=0x00000000.
- DIV/DIVU: DIV 0xFFFFFFF9/0x00000002 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU same operands -> LO=0x7FFFFFFC, HI=0x00000001.
- Corner divides: DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. DIVU 0x00000005/0 -> LO=0xFFFFFFFF, HI=0x00000005.
- MTHI/MTLO and ignored inputs:
  - In IDLE, HIWrite with SrcA=0x12345678 -> HI=0x12345678 next cycle, LO unchanged.
  - Start (MULTU 3*4) with LOWrite in the same cycle -> LOWrite ignored; final LO=0x0000000C, HI=0.
  - LOWrite and a second Start during Busy -> both ignored; the result matches the first operation.
- Reset mid-operation: start DIVU 100/7, assert reset_n=0 at the 10th Busy cycle -> next edge Busy=0, HI=LO=0, no Done pulse. A fresh MULTU 6*7 then gives LO=0x0000002A, HI=0.
